reg_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the 8x16 general-purpose register file for one instruction at a time. It accepts a 16-bit instruction over a valid/ready handshake and drives the register file selects and enables. It starts the ALU and waits for its completion, and selects the write-back source. It sits between instruction fetch and the register file/ALU datapath.

---
 rtl/reg_sequencer_pkg.sv | 31 +++
 rtl/reg_sequencer_decode.sv | 39 +++
 rtl/reg_sequencer.sv | 150 +++++++++++++++
 tb/tb_reg_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/reg_sequencer_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM states,
// write-back mux encoding and the imm9 sign-extension helper.
package reg_sequencer_pkg;

  // FSM states; IDLE is encoded as zero so a cleared debug view reads IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_READ   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_OUTP   = 3'd5
  } state_e;

  // Opcodes in instr[15:12]. 1..7 are ALU ops and A..E are illegal.
  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_OUT = 4'h9;
  localparam logic [3:0] OP_NOP = 4'hF;

  // Write-back mux select values.
  localparam logic [1:0] WB_SRC = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_IMM = 2'd2;

  // Sign-extend the 9-bit immediate to the 16-bit datapath width.
  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

endpackage

// File: rtl/reg_sequencer_decode.sv
// Combinational instruction classifier: turns the held instruction register
// into one-hot class flags, the write-protection flag, alu_op and imm.
module reg_seq_decode
  import reg_sequencer_pkg::*;
#(
  parameter bit PROTECT_CONST = 1'b1
) (
  input  logic [15:0] ir,
  output logic        is_mov,
  output logic        is_alu,
  output logic        is_ldi,
  output logic        is_out,
  output logic        is_nop,
  output logic        illegal,
  output logic        prot,
  output logic [2:0]  alu_op,
  output logic [15:0] imm
);

  logic [3:0] op;
  logic [2:0] dst;

  assign op  = ir[15:12];
  assign dst = ir[11:9];

  // Classify the opcode; r0/r1 hold constants, so writes to them are refused.
  always_comb begin
    is_mov  = (op == OP_MOV);
    is_alu  = (op[3] == 1'b0) && (op != OP_MOV);
    is_ldi  = (op == OP_LDI);
    is_out  = (op == OP_OUT);
    is_nop  = (op == OP_NOP);
    illegal = (op >= 4'hA) && (op <= 4'hE);
    prot    = PROTECT_CONST && (dst < 3'd2) && (is_mov || is_alu || is_ldi);
    alu_op  = op[2:0];
    imm     = sext9(ir[8:0]);
  end

endmodule

// File: rtl/reg_sequencer.sv
// Multi-cycle sequencer for the 8x16 register file: accepts one instruction,
// steps it through DECODE/READ/EXEC/WB/OUTP and raises done or err once.
//
// Handshake: an instruction transfers on the rising edge where instr_valid
// and instr_ready are both high; instr_ready is high only in IDLE, so there
// is never more than one instruction in flight.
module reg_sequencer
  import reg_sequencer_pkg::*;
#(
  parameter int ALU_TIMEOUT   = 16,
  parameter bit PROTECT_CONST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  rf_src_sel,
  output logic [2:0]  rf_dst_sel,
  output logic        rf_in_en,
  output logic        rf_out_en,
  output logic [1:0]  wb_sel,
  output logic [15:0] imm,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  input  logic        alu_done,
  output logic        busy,
  output logic        done,
  output logic        err,
  output state_e      state_dbg
);

  localparam int CNT_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

  state_e           state;
  logic [15:0]      ir;
  logic [CNT_W-1:0] cnt;

  logic        is_mov, is_alu, is_ldi, is_out, is_nop, illegal, prot;
  logic [2:0]  dec_alu_op;
  logic [15:0] dec_imm;

  reg_seq_decode #(.PROTECT_CONST(PROTECT_CONST)) u_decode (
    .ir      (ir),
    .is_mov  (is_mov),
    .is_alu  (is_alu),
    .is_ldi  (is_ldi),
    .is_out  (is_out),
    .is_nop  (is_nop),
    .illegal (illegal),
    .prot    (prot),
    .alu_op  (dec_alu_op),
    .imm     (dec_imm)
  );

  // State, instruction register and EXEC timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (illegal || prot || is_nop) state <= ST_IDLE;
          else if (is_ldi)               state <= ST_WB;
          else if (is_out)               state <= ST_OUTP;
          else                           state <= ST_READ;
        end
        ST_READ: begin
          cnt <= '0;
          if (is_mov) state <= ST_WB;
          else        state <= ST_EXEC;
        end
        ST_EXEC: begin
          // The last counted cycle always aborts, so err is never followed
          // by a write-back for the same instruction.
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (alu_done) begin
            state <= ST_WB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WB:   state <= ST_IDLE;
        ST_OUTP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Moore output decode from state and IR; everything is forced low in reset.
  always_comb begin
    instr_ready = 1'b0;
    rf_src_sel  = '0;
    rf_dst_sel  = '0;
    rf_in_en    = 1'b0;
    rf_out_en   = 1'b0;
    wb_sel      = WB_SRC;
    imm         = '0;
    alu_start   = 1'b0;
    alu_op      = '0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    state_dbg   = ST_IDLE;
    if (!rst) begin
      state_dbg = state;
      if (state == ST_IDLE) begin
        instr_ready = 1'b1;
      end else begin
        busy       = 1'b1;
        rf_src_sel = ir[8:6];
        rf_dst_sel = ir[11:9];
        imm        = dec_imm;
        alu_op     = dec_alu_op;
      end
      case (state)
        ST_DECODE: begin
          err  = illegal || prot;
          done = is_nop && !illegal;
        end
        ST_READ: alu_start = is_alu;
        ST_EXEC: err = (cnt == CNT_LAST);
        ST_WB: begin
          rf_in_en = 1'b1;
          done     = 1'b1;
          if (is_ldi)      wb_sel = WB_IMM;
          else if (is_alu) wb_sel = WB_ALU;
          else             wb_sel = WB_SRC;
        end
        ST_OUTP: begin
          rf_out_en = 1'b1;
          done      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed plus randomized bench for reg_sequencer. A per-instruction model
// predicts outcome, final cycle and side effects from the opcode rules.
module tb_reg_sequencer;
  import reg_sequencer_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        alu_done = 1'b0;
  logic        instr_ready, rf_in_en, rf_out_en, alu_start, busy, done, err;
  logic [2:0]  rf_src_sel, rf_dst_sel, alu_op;
  logic [1:0]  wb_sel;
  logic [15:0] imm;
  state_e      state_dbg;

  int compared   = 0;
  int mismatched = 0;

  // Clock and DUT.
  always #5 clk = ~clk;

  reg_sequencer #(.ALU_TIMEOUT(TIMEOUT), .PROTECT_CONST(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_src_sel(rf_src_sel), .rf_dst_sel(rf_dst_sel),
    .rf_in_en(rf_in_en), .rf_out_en(rf_out_en), .wb_sel(wb_sel), .imm(imm),
    .alu_start(alu_start), .alu_op(alu_op), .alu_done(alu_done), .busy(busy),
    .done(done), .err(err), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(instr_ready), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_err"},   32'(err), 0);
    check({tag, "_in_en"}, 32'(rf_in_en), 0);
    check({tag, "_out_en"}, 32'(rf_out_en), 0);
    check({tag, "_start"}, 32'(alu_start), 0);
    check({tag, "_sels"},  32'({rf_src_sel, rf_dst_sel, wb_sel, alu_op}), 0);
    check({tag, "_imm"},   32'(imm), 0);
    check({tag, "_state"}, 32'(state_dbg), 0);
  endtask

  // Reference: outcome of one instruction from the opcode rules.
  // d = EXEC cycle (1-based) in which alu_done is presented for ALU ops.
  task automatic model(input logic [15:0] ins, input int d,
                       output int fin, output bit ok, output bit wr,
                       output logic [1:0] wsel, output bit outp, output bit alu);
    int op, dst;
    op = int'(ins[15:12]);
    dst = int'(ins[11:9]);
    fin = 1; ok = 0; wr = 0; wsel = 0; outp = 0; alu = 0;
    if (op >= 10 && op <= 14) begin
      fin = 1; ok = 0;
    end else if (op == 15) begin
      fin = 1; ok = 1;
    end else if (op <= 8 && dst < 2) begin
      fin = 1; ok = 0;
    end else if (op == 8) begin
      fin = 2; ok = 1; wr = 1; wsel = 2;
    end else if (op == 9) begin
      fin = 2; ok = 1; outp = 1;
    end else if (op == 0) begin
      fin = 3; ok = 1; wr = 1; wsel = 0;
    end else begin
      alu = 1;
      if (d <= TIMEOUT - 1) begin
        fin = 3 + d; ok = 1; wr = 1; wsel = 1;
      end else begin
        fin = 2 + TIMEOUT; ok = 0;
      end
    end
  endtask

  // Driver: offer ins from an IDLE negedge, follow it to the first IDLE cycle after it.
  task automatic run_instr(input logic [15:0] ins, input int d);
    int fin;
    bit ok, wr, outp, alu;
    logic [1:0] wsel;
    int sval;
    logic [15:0] exp_imm;
    model(ins, d, fin, ok, wr, wsel, outp, alu);
    sval = ins[8] ? int'(ins[8:0]) - 512 : int'(ins[8:0]);
    exp_imm = 16'(sval);
    instr_valid = 1'b1;
    instr = ins;
    check("ready_idle", 32'(instr_ready), 1);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 16'($urandom);
    for (int c = 1; c <= fin; c++) begin
      check("busy", 32'(busy), 1);
      check("ready_busy", 32'(instr_ready), 0);
      check("done", 32'(done), 32'(c == fin && ok));
      check("err", 32'(err), 32'(c == fin && !ok));
      check("rf_in_en", 32'(rf_in_en), 32'(c == fin && wr));
      check("rf_out_en", 32'(rf_out_en), 32'(c == fin && outp));
      check("alu_start", 32'(alu_start), 32'(alu && c == 2));
      check("src_sel", 32'(rf_src_sel), 32'(ins[8:6]));
      check("dst_sel", 32'(rf_dst_sel), 32'(ins[11:9]));
      check("imm", 32'(imm), 32'(exp_imm));
      if (c == fin && wr) check("wb_sel", 32'(wb_sel), 32'(wsel));
      if (alu) check("alu_op", 32'(alu_op), 32'(ins[14:12]));
      if (alu) alu_done = (c <= 2) ? 1'($urandom_range(0, 1)) : (c == 2 + d);
      else     alu_done = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    alu_done = 1'b0;
    check("post_busy", 32'(busy), 0);
    check("post_done_err", 32'({done, err}), 0);
  endtask

  initial begin
    logic [15:0] ins;
    // Reset with an instruction offered: nothing may be accepted or driven.
    instr_valid = 1'b1;
    instr = 16'h0680;
    @(negedge clk);
    check_all_zero("rst");
    @(negedge clk);
    check_all_zero("rst2");
    instr_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(instr_ready), 1);

    // Directed cases.
    run_instr(16'h0680, 0);    // MOV r3<-r2
    run_instr(16'h89FF, 0);    // LDI r4,-1
    run_instr(16'h3B80, 3);    // ALU op3, done 3 cycles after start
    run_instr(16'h3B80, 1);    // ALU, fastest completion
    run_instr(16'h3B80, 15);   // ALU, completes in last non-abort cycle
    run_instr(16'h3B80, 99);   // ALU timeout
    // alu_done in IDLE after the timeout must be ignored.
    alu_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ignore_busy", 32'(busy), 0);
      check("idle_ignore_wr", 32'({rf_in_en, done, err}), 0);
    end
    alu_done = 1'b0;
    run_instr(16'h3B80, 16);   // alu_done in the abort cycle loses
    run_instr(16'h0280, 0);    // MOV to r1: protected
    run_instr(16'h8000, 0);    // LDI to r0: protected
    run_instr(16'hA000, 0);    // illegal
    run_instr(16'hF123, 0);    // NOP
    run_instr(16'h9E00, 0);    // OUT

    // Reset during EXEC abandons the instruction.
    instr_valid = 1'b1;
    instr = 16'h3B80;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    alu_done = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid2");
    rst = 1'b0;
    #1;
    check("rst_mid_ready", 32'(instr_ready), 1);
    @(negedge clk);
    check("rst_mid_late_done", 32'({busy, rf_in_en, done, err}), 0);
    alu_done = 1'b0;

    // Randomized instructions, back to back.
    for (int i = 0; i < 60; i++) begin
      ins = 16'($urandom);
      run_instr(ins, int'($urandom_range(1, TIMEOUT + 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
